// File: rtl/div_issue_scheduler_if.sv
// div_issue_scheduler_if
//   Bundles every non-clock/reset signal of the divide issue scheduler.
//   slave  : the scheduler side (div_issue_scheduler)
//   master : the surrounding pipeline / divide block / testbench side
//   Groups: execute-stage request (in_*), divide-block issue/return (div_*),
//           ALU writeback request (alu_wb_*), register-file write (wb_*),
//           decode scoreboard probe (chk_*, hazard), status (busy, div_err).
interface div_issue_scheduler_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_alu_control;
  logic [4:0]      in_rd;
  logic [XLEN-1:0] in_op1;
  logic [XLEN-1:0] in_op2;

  logic            div_valid;
  logic [4:0]      div_alu_control;
  logic [4:0]      div_rd;
  logic [XLEN-1:0] div_op1;
  logic [XLEN-1:0] div_op2;
  logic            div_out_valid;
  logic [XLEN-1:0] div_result;

  logic            alu_wb_valid;
  logic [4:0]      alu_wb_rd;
  logic [XLEN-1:0] alu_wb_data;
  logic            alu_wb_ready;

  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  logic [4:0]      chk_rs1;
  logic [4:0]      chk_rs2;
  logic            hazard;
  logic            busy;
  logic            div_err;

  modport slave (
    input  in_valid, in_alu_control, in_rd, in_op1, in_op2,
    output in_ready,
    output div_valid, div_alu_control, div_rd, div_op1, div_op2,
    input  div_out_valid, div_result,
    input  alu_wb_valid, alu_wb_rd, alu_wb_data,
    output alu_wb_ready,
    output wb_valid, wb_rd, wb_data,
    input  chk_rs1, chk_rs2,
    output hazard, busy, div_err
  );

  modport master (
    output in_valid, in_alu_control, in_rd, in_op1, in_op2,
    input  in_ready,
    input  div_valid, div_alu_control, div_rd, div_op1, div_op2,
    output div_out_valid, div_result,
    output alu_wb_valid, alu_wb_rd, alu_wb_data,
    input  alu_wb_ready,
    input  wb_valid, wb_rd, wb_data,
    output chk_rs1, chk_rs2,
    input  hazard, busy, div_err
  );
endinterface

// File: rtl/div_issue_scheduler.sv
// div_issue_scheduler
//   Sequences DIV/DIVU/REM/REMU (alu_control 16..19) to the divide block one
//   op at a time, holds the returned result, and shares the register-file
//   write port with single-cycle ALU results (divide result wins for its one
//   WB cycle). A one-entry rd scoreboard drives the decode hazard output.
//
//   Ports: clk, rst_n (async active-low), bus (div_issue_scheduler_if.slave).
//   Parameters: XLEN (data width), TIMEOUT (WAIT cycle limit).
//   Build option: define DIV_TIMEOUT_EN to build the WAIT watchdog; when it
//   fires, div_err sets (sticky until reset) and the op is dropped. Without
//   it, div_err is tied 0 and WAIT lasts until the divide block answers.
module div_issue_scheduler #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 80
) (
  input  logic                  clk,
  input  logic                  rst_n,
  div_issue_scheduler_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  typedef struct packed {
    logic [4:0]      ctrl;
    logic [4:0]      rd;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
  } div_req_t;

  if (TIMEOUT < 1) begin : g_bad_timeout_cfg
    $error("div_issue_scheduler: TIMEOUT must be >= 1");
  end

  logic [1:0]      state_q, state_d;
  div_req_t        req_q, req_d;
  logic [XLEN-1:0] res_q, res_d;

  logic is_div_op, accept, timeout_hit;

  assign is_div_op = (bus.in_alu_control >= 5'd16) && (bus.in_alu_control <= 5'd19);
  assign accept    = bus.in_valid && (state_q == S_IDLE) && is_div_op;

`ifdef DIV_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // cnt_q holds the number of WAIT cycles already spent, so the TIMEOUT-th
  // WAIT cycle sees TIMEOUT-1. A result in that same cycle still wins.
  assign timeout_hit = (state_q == S_WAIT) && !bus.div_out_valid &&
                       (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = '0;
    if (state_q == S_WAIT) cnt_d = cnt_q + CW'(1);
    err_d = err_q | timeout_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.div_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign bus.div_err = 1'b0;
`endif

  // Sequencer
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        // Returns seen here (e.g. after a reset mid-op) are ignored.
        if (accept) begin
          req_d.ctrl = bus.in_alu_control;
          req_d.rd   = bus.in_rd;
          req_d.op1  = bus.in_op1;
          req_d.op2  = bus.in_op2;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.div_out_valid) begin
          res_d   = bus.div_result;
          // x0 destination: nothing to write, free the port immediately.
          state_d = (req_q.rd == 5'd0) ? S_IDLE : S_WB;
        end else if (timeout_hit) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;  // S_WB lasts exactly one cycle
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      res_q   <= res_d;
    end
  end

  assign bus.in_ready        = (state_q == S_IDLE);
  assign bus.busy            = (state_q != S_IDLE);
  assign bus.div_valid       = (state_q == S_ISSUE);
  assign bus.div_alu_control = req_q.ctrl;
  assign bus.div_rd          = req_q.rd;
  assign bus.div_op1         = req_q.op1;
  assign bus.div_op2         = req_q.op2;

  // Write-port mux: divide result owns the port in WB, ALU otherwise.
  always_comb begin
    if (state_q == S_WB) begin
      bus.wb_valid     = 1'b1;
      bus.wb_rd        = req_q.rd;
      bus.wb_data      = res_q;
      bus.alu_wb_ready = 1'b0;
    end else begin
      bus.wb_valid     = bus.alu_wb_valid && (bus.alu_wb_rd != 5'd0);
      bus.wb_rd        = bus.alu_wb_rd;
      bus.wb_data      = bus.alu_wb_data;
      bus.alu_wb_ready = 1'b1;
    end
  end

  // Scoreboard: the in-flight rd, plus the rd being accepted this cycle so
  // decode stalls a dependent op issued right behind the divide.
  logic busy_hz, acc_hz;

  assign busy_hz = (state_q != S_IDLE) && (req_q.rd != 5'd0) &&
                   ((req_q.rd == bus.chk_rs1) || (req_q.rd == bus.chk_rs2));
  assign acc_hz  = accept && (bus.in_rd != 5'd0) &&
                   ((bus.in_rd == bus.chk_rs1) || (bus.in_rd == bus.chk_rs2));
  assign bus.hazard = busy_hz || acc_hz;

endmodule
